// File: rtl/proc_multicycle.sv
// proc_multicycle: multi-cycle RV32 subset core, FETCH/EXEC/MEM/WB FSM with req/ready memory ports.
// Define PROC_MC_ITER_DIV_EN for a 32-cycle iterative divider; div/rem (funct3 100/110) are unsigned.
module proc_multicycle #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter bit          REG_CLEAR = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] instruction,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        trap,
    output logic        retire
);
`ifdef PROC_MC_ITER_DIV_EN
    typedef enum logic [2:0] {FETCH, EXEC, MEM, WB, TRAP, DIV} state_t;
`else
    typedef enum logic [2:0] {FETCH, EXEC, MEM, WB, TRAP} state_t;
`endif
    state_t      state;
    logic [31:0] pc, ir, res, npc, a, b, alu, sra_v, mdv, npc_c;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rf [32];
    logic        wen;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic        is_r, is_add, is_sub, is_and, is_slt, is_sll, is_srl, is_sra, is_div, is_rem;
    logic        is_addi, is_lw, is_sw, is_beq, is_blt, is_lui, is_auipc, is_jal, is_jalr, legal;

    assign op = ir[6:0];
    assign rd = ir[11:7];
    assign f3 = ir[14:12];
    assign rs1 = ir[19:15];
    assign rs2 = ir[24:20];
    assign f7 = ir[31:25];
    assign imem_addr = pc;
    assign a = rs1 == 5'd0 ? 32'd0 : rf[rs1];
    assign b = rs2 == 5'd0 ? 32'd0 : rf[rs2];
    assign imm_i = {{20{ir[31]}}, ir[31:20]};
    assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_u = {ir[31:12], 12'd0};
    assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    assign is_r = op == 7'h33;
    assign is_add = is_r && f7 == 7'h00 && f3 == 3'd0;
    assign is_sub = is_r && f7 == 7'h20 && f3 == 3'd0;
    assign is_and = is_r && f7 == 7'h00 && f3 == 3'd7;
    assign is_slt = is_r && f7 == 7'h00 && f3 == 3'd2;
    assign is_sll = is_r && f7 == 7'h00 && f3 == 3'd1;
    assign is_srl = is_r && f7 == 7'h00 && f3 == 3'd5;
    assign is_sra = is_r && f7 == 7'h20 && f3 == 3'd5;
    assign is_div = is_r && f7 == 7'h01 && f3 == 3'd4;
    assign is_rem = is_r && f7 == 7'h01 && f3 == 3'd6;
    assign is_addi = op == 7'h13 && f3 == 3'd0;
    assign is_lw = op == 7'h03 && f3 == 3'd2;
    assign is_sw = op == 7'h23 && f3 == 3'd2;
    assign is_beq = op == 7'h63 && f3 == 3'd0;
    assign is_blt = op == 7'h63 && f3 == 3'd4;
    assign is_lui = op == 7'h37;
    assign is_auipc = op == 7'h17;
    assign is_jal = op == 7'h6F;
    assign is_jalr = op == 7'h67 && f3 == 3'd0;
    assign legal = is_add | is_sub | is_and | is_slt | is_sll | is_srl | is_sra | is_div | is_rem
                 | is_addi | is_lw | is_sw | is_beq | is_blt | is_lui | is_auipc | is_jal | is_jalr;

    // kept separate so the ternary chain below cannot strip the signedness of the shift
    assign sra_v = $signed(a) >>> b[4:0];

`ifdef PROC_MC_ITER_DIV_EN
    logic [31:0] dq, dr, q_n, r_n;
    logic [32:0] rs_sh, diff;
    logic [4:0]  dcnt;
    assign mdv = 32'd0;
    assign rs_sh = {dr, dq[31]};
    assign diff = rs_sh - {1'b0, b};
    assign q_n = {dq[30:0], ~diff[32]};
    assign r_n = diff[32] ? rs_sh[31:0] : diff[31:0];
`else
    assign mdv = b == 32'd0 ? (is_rem ? a : 32'hFFFF_FFFF) : (is_rem ? a % b : a / b);
`endif

    always_comb begin
        alu = is_add ? a + b : is_sub ? a - b : is_and ? a & b : is_slt ? {31'd0, $signed(a) < $signed(b)}
            : is_sll ? a << b[4:0] : is_srl ? a >> b[4:0] : is_sra ? sra_v : is_addi ? a + imm_i
            : is_lui ? imm_u : is_auipc ? pc + imm_u : (is_jal | is_jalr) ? pc + 32'd4 : mdv;
        npc_c = ((is_beq && a == b) || (is_blt && $signed(a) < $signed(b))) ? pc + imm_b
              : is_jal ? pc + imm_j : is_jalr ? (a + imm_i) & ~32'd1 : pc + 32'd4;
    end

    always_ff @(posedge clk) begin
        retire <= 1'b0;
        if (reset) begin
            state <= FETCH;
            pc <= RESET_PC;
            imem_req <= 1'b0;
            dmem_req <= 1'b0;
            dmem_we <= 1'b0;
            dmem_addr <= 32'd0;
            dmem_wdata <= 32'd0;
            trap <= 1'b0;
            if (REG_CLEAR) for (int i = 1; i < 32; i++) rf[i] <= 32'd0;
        end else begin
            case (state)
                FETCH: if (!imem_req) imem_req <= 1'b1;
                       else if (imem_ready) begin
                           ir <= instruction;
                           imem_req <= 1'b0;
                           state <= EXEC;
                       end
                EXEC: begin
                    res <= alu;
                    npc <= npc_c;
                    wen <= !(is_sw || is_beq || is_blt);
                    if (!legal) begin
                        trap <= 1'b1;
                        state <= TRAP;
                    end else if (is_lw || is_sw) begin
                        dmem_req <= 1'b1;
                        dmem_we <= is_sw;
                        dmem_addr <= a + (is_sw ? imm_s : imm_i);
                        dmem_wdata <= b;
                        state <= MEM;
`ifdef PROC_MC_ITER_DIV_EN
                    end else if (is_div || is_rem) begin
                        dq <= a;
                        dr <= 32'd0;
                        dcnt <= 5'd0;
                        state <= DIV;
`endif
                    end else begin
                        retire <= 1'b1;
                        state <= WB;
                    end
                end
                MEM: if (dmem_ready) begin
                    dmem_req <= 1'b0;
                    if (!dmem_we) res <= dmem_rdata;
                    retire <= 1'b1;
                    state <= WB;
                end
`ifdef PROC_MC_ITER_DIV_EN
                DIV: begin
                    dq <= q_n;
                    dr <= r_n;
                    dcnt <= dcnt + 5'd1;
                    if (dcnt == 5'd31) begin
                        res <= is_rem ? r_n : q_n;
                        retire <= 1'b1;
                        state <= WB;
                    end
                end
`endif
                WB: begin
                    if (wen && rd != 5'd0) rf[rd] <= res;
                    pc <= npc;
                    imem_req <= 1'b1;
                    state <= FETCH;
                end
                default: ; // TRAP holds until reset
            endcase
        end
    end
endmodule

// File: tb/tb_proc_multicycle.sv
// tb_proc_multicycle: random and directed instruction streams checked cycle by cycle against an ISA-level model.
module tb_proc_multicycle;
    logic        clk = 1'b0, reset = 1'b1;
    logic        imem_req, imem_ready = 1'b0, dmem_req, dmem_we, dmem_ready = 1'b0, trap, retire;
    logic [31:0] imem_addr, instruction = 32'd0, dmem_addr, dmem_wdata, dmem_rdata = 32'd0;
    int          vec = 0, errs = 0, cyc = 0, wait_pct = 0;
    logic [31:0] mr [32];
    logic [31:0] dm [logic [31:0]];
    logic [31:0] m_pc;
    logic [31:0] fetch_log [$], st_a [$], st_d [$];
    int          ret_cyc [$];
`ifdef PROC_MC_ITER_DIV_EN
    localparam int DIVX = 32;
`else
    localparam int DIVX = 0;
`endif

    proc_multicycle #(.RESET_PC(32'h100), .REG_CLEAR(1'b1)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .instruction(instruction), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .trap(trap), .retire(retire));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (retire === 1'b1) ret_cyc.push_back(cyc);

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] r2, input logic [4:0] r1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, r2, r1, f3, rd, 7'h33};
    endfunction
    function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] r1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {im, r1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] im, input logic [4:0] r2, input logic [4:0] r1);
        return {im[11:5], r2, r1, 3'd2, im[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] im, input logic [4:0] r2, input logic [4:0] r1,
                                          input logic [2:0] f3);
        return {im[12], im[10:5], r2, r1, f3, im[4:1], im[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] im, input logic [4:0] rd);
        return {im[20], im[10:1], im[11], im[19:12], rd, 7'h6F};
    endfunction

    // ISA-level step: kind 0 = plain, 1 = memory, 2 = divide, 3 = illegal
    function automatic void iss(input logic [31:0] w, output int kind, output logic [31:0] ea,
                                output logic [31:0] wd, output logic we, output logic [31:0] rv);
        logic [31:0] s1 = mr[w[19:15]], s2 = mr[w[24:20]];
        logic [31:0] ii = {{20{w[31]}}, w[31:20]};
        logic [31:0] is = {{20{w[31]}}, w[31:25], w[11:7]};
        logic [31:0] ib = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
        logic [31:0] ij = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
        logic [31:0] iu = {w[31:12], 12'd0};
        logic [31:0] np = m_pc + 32'd4, v = 32'd0;
        logic [4:0]  sh = s2[4:0];
        logic [2:0]  f3 = w[14:12];
        logic        wr = 1'b1;
        kind = 0; ea = 32'd0; wd = 32'd0; we = 1'b0;
        case (w[6:0])
            7'h33: case ({w[31:25], f3})
                {7'h00, 3'd0}: v = s1 + s2;
                {7'h20, 3'd0}: v = s1 - s2;
                {7'h00, 3'd7}: v = s1 & s2;
                {7'h00, 3'd2}: v = ($signed(s1) < $signed(s2)) ? 32'd1 : 32'd0;
                {7'h00, 3'd1}: v = s1 << sh;
                {7'h00, 3'd5}: v = s1 >> sh;
                {7'h20, 3'd5}: v = (s1 >> sh) | (s1[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
                {7'h01, 3'd4}: begin v = s2 == 0 ? 32'hFFFF_FFFF : s1 / s2; kind = 2; end
                {7'h01, 3'd6}: begin v = s2 == 0 ? s1 : s1 % s2; kind = 2; end
                default: kind = 3;
            endcase
            7'h13: if (f3 == 3'd0) v = s1 + ii; else kind = 3;
            7'h03: if (f3 == 3'd2) begin
                kind = 1; ea = s1 + ii;
                if (!dm.exists(ea)) dm[ea] = $urandom;
                v = dm[ea];
            end else kind = 3;
            7'h23: if (f3 == 3'd2) begin
                kind = 1; ea = s1 + is; wd = s2; we = 1'b1; dm[ea] = s2; wr = 1'b0;
            end else kind = 3;
            7'h63: begin
                wr = 1'b0;
                if (f3 == 3'd0) begin if (s1 == s2) np = m_pc + ib; end
                else if (f3 == 3'd4) begin if ($signed(s1) < $signed(s2)) np = m_pc + ib; end
                else kind = 3;
            end
            7'h37: v = iu;
            7'h17: v = m_pc + iu;
            7'h6F: begin v = m_pc + 32'd4; np = m_pc + ij; end
            7'h67: if (f3 == 3'd0) begin v = m_pc + 32'd4; np = (s1 + ii) & ~32'd1; end else kind = 3;
            default: kind = 3;
        endcase
        rv = v;
        if (kind != 3) begin
            if (wr && w[11:7] != 5'd0) mr[w[11:7]] = v;
            m_pc = np;
        end
    endfunction

    task automatic do_reset();
        reset = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_imem_req", imem_req, 0); chk("rst_dmem_req", dmem_req, 0); chk("rst_dmem_we", dmem_we, 0);
        chk("rst_retire", retire, 0); chk("rst_trap", trap, 0); chk("rst_imem_addr", imem_addr, 32'h100);
        chk("rst_dmem_addr", dmem_addr, 0); chk("rst_dmem_wdata", dmem_wdata, 0);
        for (int i = 0; i < 32; i++) mr[i] = 32'd0;
        m_pc = 32'h100;
        reset = 1'b0;
    endtask

    // one instruction: iw/dw force that many not-ready cycles on each port; abort resets mid-MEM
    task automatic do_instr(input logic [31:0] w, input int iw = 0, input int dw = 0, input bit abort = 0);
        int kind, n;
        logic [31:0] ea, wd, rv;
        logic we;
        n = 0;
        do begin
            @(negedge clk);
            chk("imem_req", imem_req, 1); chk("imem_addr", imem_addr, m_pc);
            chk("dmem_req_fetch", dmem_req, 0); chk("retire_fetch", retire, 0); chk("trap_fetch", trap, 0);
            imem_ready = n >= iw && (n >= iw + 6 || $urandom_range(99) >= wait_pct);
            instruction = imem_ready ? w : $urandom;
            dmem_ready = $urandom_range(1);
            n++;
        end while (!imem_ready);
        fetch_log.push_back(imem_addr);
        iss(w, kind, ea, wd, we, rv);
        @(negedge clk);
        chk("imem_req_exec", imem_req, 0); chk("dmem_req_exec", dmem_req, 0);
        chk("retire_exec", retire, 0); chk("trap_exec", trap, 0);
        imem_ready = $urandom_range(1); dmem_ready = $urandom_range(1);
        if (kind == 3) begin
            repeat (6) begin
                @(negedge clk);
                chk("trap", trap, 1); chk("imem_req_trap", imem_req, 0); chk("dmem_req_trap", dmem_req, 0);
                chk("retire_trap", retire, 0); chk("imem_addr_trap", imem_addr, m_pc);
                imem_ready = 1'b1;
            end
            return;
        end
        if (kind == 1) begin
            n = 0;
            do begin
                @(negedge clk);
                chk("dmem_req", dmem_req, 1); chk("dmem_we", dmem_we, we); chk("dmem_addr", dmem_addr, ea);
                if (we) chk("dmem_wdata", dmem_wdata, wd);
                chk("retire_mem", retire, 0); chk("imem_req_mem", imem_req, 0);
                if (abort) begin
                    reset = 1'b1; dmem_ready = 1'b1;
                    @(negedge clk);
                    chk("dmem_req_abort", dmem_req, 0); chk("retire_abort", retire, 0);
                    return;
                end
                dmem_ready = n >= dw && (n >= dw + 6 || $urandom_range(99) >= wait_pct);
                dmem_rdata = dmem_ready ? rv : $urandom;
                imem_ready = $urandom_range(1);
                n++;
            end while (!dmem_ready);
            if (we) begin st_a.push_back(dmem_addr); st_d.push_back(dmem_wdata); end
        end else if (kind == 2) begin
            repeat (DIVX) begin
                @(negedge clk);
                chk("retire_div", retire, 0); chk("imem_req_div", imem_req, 0); chk("dmem_req_div", dmem_req, 0);
                imem_ready = $urandom_range(1); dmem_ready = $urandom_range(1);
            end
        end
        @(negedge clk);
        chk("retire", retire, 1); chk("imem_req_wb", imem_req, 0); chk("dmem_req_wb", dmem_req, 0);
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [4:0]  rd = 5'($urandom_range(15)), r1 = 5'($urandom_range(15)), r2 = 5'($urandom_range(15));
        logic [11:0] im = 12'($urandom);
        logic [11:0] mo = 12'(4 * $urandom_range(15));
        logic [2:0]  f3s [7] = '{3'd0, 3'd0, 3'd7, 3'd2, 3'd1, 3'd5, 3'd5};
        int          off = (int'($urandom_range(32)) - 16) * 4;
        int          f = $urandom_range(6);
        case ($urandom_range(15))
            0, 1:   return enc_r((f == 1 || f == 6) ? 7'h20 : 7'h00, r2, r1, f3s[f], rd);
            2, 3:   return enc_i(im, r1, 3'd0, rd, 7'h13);
            4:      return enc_r(7'h01, r2, r1, $urandom_range(1) ? 3'd4 : 3'd6, rd);
            5:      return {20'($urandom), rd, 7'h37};
            6:      return {20'($urandom), rd, 7'h17};
            7, 8:   return enc_i(mo, 5'd0, 3'd2, rd, 7'h03);
            9, 10:  return enc_s(mo, r2, 5'd0);
            11:     return enc_s(im, r2, r1);
            12:     return enc_b(off[12:0], r2, r1, $urandom_range(1) ? 3'd0 : 3'd4);
            13:     return enc_j(off[20:0], rd);
            14:     return enc_i(im, r1, 3'd0, rd, 7'h67);
            default: return enc_i(im, r1, 3'd0, rd, 7'h13);
        endcase
    endfunction

    initial begin
        do_reset();
        do_instr(enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13));
        do_instr(enc_i(12'hFF9, 5'd1, 3'd0, 5'd2, 7'h13));
        chk("model_x2", mr[2], 32'hFFFF_FFFE);
        do_instr(enc_i(12'd100, 5'd0, 3'd0, 5'd4, 7'h13), 4);
        do_instr(enc_s(12'd8, 5'd2, 5'd0), 0, 2);
        do_instr(enc_i(12'd8, 5'd0, 3'd2, 5'd3, 7'h03), 0, 2);
        do_instr(enc_s(12'd12, 5'd3, 5'd0));
        do_instr(enc_i(12'hFFF, 5'd0, 3'd0, 5'd1, 7'h13));
        do_instr(enc_i(12'd1, 5'd0, 3'd0, 5'd2, 7'h13));
        do_instr(enc_b(13'd16, 5'd2, 5'd1, 3'd4));
        do_instr(enc_b(13'd16, 5'd2, 5'd1, 3'd0));
        do_instr(enc_i(12'h203, 5'd0, 3'd0, 5'd5, 7'h13));
        do_instr(enc_i(12'd0, 5'd5, 3'd0, 5'd6, 7'h67));
        do_instr(enc_s(12'd16, 5'd6, 5'd0));
        do_instr(enc_i(12'd100, 5'd0, 3'd0, 5'd7, 7'h13));
        do_instr(enc_i(12'd7, 5'd0, 3'd0, 5'd8, 7'h13));
        do_instr(enc_r(7'h01, 5'd8, 5'd7, 3'd4, 5'd9));
        do_instr(enc_r(7'h01, 5'd8, 5'd7, 3'd6, 5'd10));
        do_instr(enc_r(7'h01, 5'd0, 5'd7, 3'd4, 5'd11));
        do_instr(enc_r(7'h01, 5'd0, 5'd7, 3'd6, 5'd12));
        for (int r = 9; r <= 12; r++) do_instr(enc_s(12'(20 + 4 * (r - 9)), 5'(r), 5'd0));
        chk("reset_vector", fetch_log[0], 32'h100);
        chk("retire_gap_alu", ret_cyc[1] - ret_cyc[0], 3);
        chk("lat_imem_wait4", ret_cyc[2] - ret_cyc[1], 7);
        chk("lat_sw_wait2", ret_cyc[3] - ret_cyc[2], 6);
        chk("lat_lw_wait2", ret_cyc[4] - ret_cyc[3], 6);
        chk("lat_div", ret_cyc[15] - ret_cyc[14], 3 + DIVX);
        chk("lat_rem0", ret_cyc[18] - ret_cyc[17], 3 + DIVX);
        chk("sw_addr", st_a[0], 32'd8);
        chk("sw_data_x2", st_d[0], 32'hFFFF_FFFE);
        chk("lw_x3", st_d[1], 32'hFFFF_FFFE);
        chk("blt_taken", fetch_log[9], 32'h130);
        chk("beq_not_taken", fetch_log[10], 32'h134);
        chk("jalr_target", fetch_log[12], 32'h202);
        chk("jalr_link", st_d[2], 32'h13C);
        chk("div_100_7", st_d[3], 32'd14);
        chk("rem_100_7", st_d[4], 32'd2);
        chk("div_by_0", st_d[5], 32'hFFFF_FFFF);
        chk("rem_by_0", st_d[6], 32'd100);
        do_instr(32'h0000_007F);
        do_reset();
        do_instr(enc_i(12'd8, 5'd0, 3'd2, 5'd13, 7'h03), 0, 1, 1);
        do_reset();
        do_instr(enc_s(12'd36, 5'd13, 5'd0));
        chk("abort_no_write", st_d[st_d.size() - 1], 32'd0);
        wait_pct = 30;
        repeat (300) do_instr(rnd_instr());
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
